pwm_multi: RTL and testbench

- Parametrised multi-channel PWM generator.
- Provides NUM_CH independent duty-cycle outputs from one shared WIDTH-bit period counter with a clock prescaler.
- Duty and period are programmable at run time through a single-cycle write port; values are double-buffered so a change never glitches a running period.
- Sits between switch/host control logic and LED or motor-drive pins; succeeds the fixed four-level, single-channel PWM.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_timebase.sv | 46 ++++
 rtl/pwm_multi.sv | 95 +++++++++
 tb/tb_pwm_multi.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

  localparam int DEFAULT_PERIOD = 255;
  localparam int DEFAULT_PRESC  = 0;

  // Presets for 8-bit switch-selected duty wrappers (~20/40/60/80 %).
  localparam logic [7:0] DUTY_20 = 8'd51;
  localparam logic [7:0] DUTY_40 = 8'd103;
  localparam logic [7:0] DUTY_60 = 8'd154;
  localparam logic [7:0] DUTY_80 = 8'd205;

  function automatic int ADDR_W(input int num_ch);
    return (num_ch < 1) ? 1 : $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus shared period counter; wrap marks the last tick of a period.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic [WIDTH-1:0]   period_act,
  output logic [WIDTH-1:0]   cnt,
  output logic               wrap
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               tick;

  always_comb begin
    tick    = en && (presc_q == presc_div);
    wrap    = tick && (cnt_q == period_act);
    presc_d = '0;
    cnt_d   = '0;
    if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (wrap)      cnt_d = '0;
      else if (tick) cnt_d = cnt_q + 1'b1;
      else           cnt_d = cnt_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared timebase, double-buffered duty/period registers,
// one registered compare slice per channel.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                NUM_CH         = 2,
  parameter int                WIDTH          = 8,
  parameter int                PRESC_W        = 8,
  parameter int unsigned       DEFAULT_PERIOD = pwm_pkg::DEFAULT_PERIOD,
  parameter logic [NUM_CH-1:0] POLARITY       = '0
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic                        en,
  input  logic [PRESC_W-1:0]          presc_div,
  input  logic                        wr_en,
  input  logic [ADDR_W(NUM_CH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic                        period_tick
);

  localparam int AW = ADDR_W(NUM_CH);

  logic [WIDTH-1:0] cnt;
  logic             wrap;
  logic [WIDTH-1:0] period_pend_q, period_pend_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic             period_tick_q;

  pwm_timebase #(
    .WIDTH   (WIDTH),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (en),
    .presc_div  (presc_div),
    .period_act (period_act_q),
    .cnt        (cnt),
    .wrap       (wrap)
  );

  // While disabled the active copies track pend so writes apply immediately.
  always_comb begin
    period_pend_d = period_pend_q;
    if (wr_en && (wr_addr == AW'(NUM_CH))) period_pend_d = wr_data;
    period_act_d = period_act_q;
    if (!en || wrap) period_act_d = period_pend_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      period_pend_q <= WIDTH'(DEFAULT_PERIOD);
      period_act_q  <= WIDTH'(DEFAULT_PERIOD);
      period_tick_q <= 1'b0;
    end else begin
      period_pend_q <= period_pend_d;
      period_act_q  <= period_act_d;
      period_tick_q <= wrap;
    end
  end

  assign period_tick = period_tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] duty_pend_q, duty_pend_d;
    logic [WIDTH-1:0] duty_act_q, duty_act_d;
    logic             out_q, out_d;

    always_comb begin
      duty_pend_d = duty_pend_q;
      if (wr_en && (wr_addr == AW'(i))) duty_pend_d = wr_data;
      duty_act_d = duty_act_q;
      if (!en || wrap) duty_act_d = duty_pend_q;
      out_d = POLARITY[i];
      if (en) out_d = (cnt < duty_act_q) ^ POLARITY[i];
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        duty_pend_q <= '0;
        duty_act_q  <= '0;
        out_q       <= POLARITY[i];
      end else begin
        duty_pend_q <= duty_pend_d;
        duty_act_q  <= duty_act_d;
        out_q       <= out_d;
      end
    end

    assign pwm_out[i] = out_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: per-cycle reference model, table of
// period/duty scenarios, hand-written shadow-load and reset sequences, random run.
module tb_pwm_multi;

  localparam logic [1:0] POL = 2'b10;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       en;
  logic [7:0] presc_div;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] pwm_out;
  logic       period_tick;

  int vectors = 0;
  int miscompares = 0;

  pwm_multi #(
    .NUM_CH         (2),
    .WIDTH          (8),
    .PRESC_W        (8),
    .DEFAULT_PERIOD (255),
    .POLARITY       (POL)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .en          (en),
    .presc_div   (presc_div),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: position inside the current tick and inside the period,
  // plus the pending/applied settings.
  int         m_sub;
  int         m_pos;
  int         m_ppend, m_pact;
  int         m_dpend[2], m_dact[2];
  logic [1:0] m_out;
  logic       m_tick;

  task automatic model_step();
    bit ticked, last;
    if (sys_rst) begin
      m_sub = 0; m_pos = 0;
      m_ppend = 255; m_pact = 255;
      for (int i = 0; i < 2; i++) begin m_dpend[i] = 0; m_dact[i] = 0; end
      m_out = POL; m_tick = 1'b0;
      return;
    end
    if (en) begin
      for (int i = 0; i < 2; i++) m_out[i] = logic'(m_pos < m_dact[i]) ^ POL[i];
      ticked = (m_sub == int'(presc_div));
      last   = ticked && (m_pos == m_pact);
      m_tick = last;
      m_sub  = ticked ? 0 : (m_sub + 1) % 256;
      if (ticked) m_pos = last ? 0 : m_pos + 1;
      if (last) begin
        m_pact = m_ppend;
        for (int i = 0; i < 2; i++) m_dact[i] = m_dpend[i];
      end
    end else begin
      m_sub = 0; m_pos = 0;
      m_pact = m_ppend;
      for (int i = 0; i < 2; i++) m_dact[i] = m_dpend[i];
      m_out = POL; m_tick = 1'b0;
    end
    if (wr_en) begin
      if (wr_addr < 2)       m_dpend[wr_addr] = int'(wr_data);
      else if (wr_addr == 2) m_ppend = int'(wr_data);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    #1;
    chk("model_pwm_out", 32'(pwm_out), 32'(m_out));
    chk("model_period_tick", 32'(period_tick), 32'(m_tick));
  endtask

  task automatic wait_tick(input int limit);
    int k = 0;
    while (period_tick !== 1'b1 && k < limit) begin
      cycle();
      k++;
    end
    chk("wait_tick", 32'(period_tick), 32'd1);
  endtask

  // Counts active cycles per channel over len cycles, optionally writing at cycle wr_at;
  // tk reports the first cycle at which period_tick was seen.
  task automatic measure(input int len, input int wr_at, input logic [1:0] wa,
                         input logic [7:0] wd, output int a0, output int a1, output int tk);
    a0 = 0; a1 = 0; tk = 0;
    for (int k = 1; k <= len; k++) begin
      wr_en   = (k == wr_at);
      wr_addr = wa;
      wr_data = wd;
      cycle();
      a0 += int'(pwm_out[0] ^ POL[0]);
      a1 += int'(pwm_out[1] ^ POL[1]);
      if (period_tick === 1'b1 && tk == 0) tk = k;
    end
    wr_en = 1'b0;
  endtask

  task automatic configure(input int period, input int presc, input int d0, input int d1);
    en = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'(period); cycle();
    wr_addr = 2'd0; wr_data = 8'(d0); cycle();
    wr_addr = 2'd1; wr_data = 8'(d1); cycle();
    wr_en = 1'b0; presc_div = 8'(presc); cycle();
  endtask

  typedef struct {
    int period; int presc; int d0; int d1;
    int hi0; int hi1; int len;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int a0, a1, tk;

    tbl[0] = '{period: 255, presc: 0, d0: 51,  d1: 205, hi0: 51,  hi1: 205, len: 256};
    tbl[1] = '{period: 9,   presc: 3, d0: 5,   d1: 3,   hi0: 20,  hi1: 12,  len: 40};
    tbl[2] = '{period: 9,   presc: 0, d0: 0,   d1: 255, hi0: 0,   hi1: 10,  len: 10};
    tbl[3] = '{period: 9,   presc: 1, d0: 10,  d1: 9,   hi0: 20,  hi1: 18,  len: 20};
    tbl[4] = '{period: 255, presc: 0, d0: 255, d1: 0,   hi0: 255, hi1: 0,   len: 256};
    tbl[5] = '{period: 0,   presc: 2, d0: 1,   d1: 0,   hi0: 3,   hi1: 0,   len: 3};

    sys_rst = 1'b1; en = 1'b1; presc_div = 8'd0;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd77;
    cycle();
    chk("reset_pwm_out", 32'(pwm_out), 32'(POL));
    chk("reset_period_tick", 32'(period_tick), 32'd0);
    sys_rst = 1'b0; wr_en = 1'b0;

    foreach (tbl[n]) begin
      configure(tbl[n].period, tbl[n].presc, tbl[n].d0, tbl[n].d1);
      chk("disabled_pwm_out", 32'(pwm_out), 32'(POL));
      en = 1'b1;
      wait_tick(1000);
      measure(tbl[n].len, 0, 2'd0, 8'd0, a0, a1, tk);
      chk($sformatf("tbl%0d_tick_spacing", n), 32'(tk), 32'(tbl[n].len));
      chk($sformatf("tbl%0d_active_ch0", n), 32'(a0), 32'(tbl[n].hi0));
      chk($sformatf("tbl%0d_active_ch1", n), 32'(a1), 32'(tbl[n].hi1));
      measure(tbl[n].len, 0, 2'd0, 8'd0, a0, a1, tk);
      chk($sformatf("tbl%0d_active_ch0_again", n), 32'(a0), 32'(tbl[n].hi0));
      chk($sformatf("tbl%0d_active_ch1_again", n), 32'(a1), 32'(tbl[n].hi1));
    end

    // Mid-period write applies at next wrap; write on the wrap edge one period later.
    configure(255, 0, 51, 205);
    en = 1'b1;
    wait_tick(300);
    measure(256, 101, 2'd0, 8'd128, a0, a1, tk);
    chk("midwrite_cur_period", 32'(a0), 32'd51);
    chk("midwrite_tick", 32'(tk), 32'd256);
    measure(256, 0, 2'd0, 8'd0, a0, a1, tk);
    chk("midwrite_next_period", 32'(a0), 32'd128);
    measure(256, 256, 2'd0, 8'd77, a0, a1, tk);
    chk("wrapwrite_cur_period", 32'(a0), 32'd128);
    measure(256, 0, 2'd0, 8'd0, a0, a1, tk);
    chk("wrapwrite_one_later", 32'(a0), 32'd128);
    measure(256, 0, 2'd0, 8'd0, a0, a1, tk);
    chk("wrapwrite_applied", 32'(a0), 32'd77);
    chk("wrapwrite_ch1", 32'(a1), 32'd205);

    // Reset mid-period with a pending write; reset also overrides a period write.
    for (int k = 0; k < 50; k++) cycle();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd99; cycle();
    sys_rst = 1'b1; wr_addr = 2'd2; wr_data = 8'd5; cycle();
    sys_rst = 1'b0; wr_en = 1'b0;
    chk("midreset_pwm_out", 32'(pwm_out), 32'(POL));
    chk("midreset_period_tick", 32'(period_tick), 32'd0);
    measure(256, 0, 2'd0, 8'd0, a0, a1, tk);
    chk("postreset_tick", 32'(tk), 32'd256);
    chk("postreset_ch0", 32'(a0), 32'd0);
    chk("postreset_ch1", 32'(a1), 32'd0);
    measure(256, 10, 2'd3, 8'd1, a0, a1, tk);
    chk("badaddr_tick", 32'(tk), 32'd256);
    measure(256, 0, 2'd0, 8'd0, a0, a1, tk);
    chk("badaddr_tick_after", 32'(tk), 32'd256);
    chk("badaddr_ch0", 32'(a0), 32'd0);
    chk("badaddr_ch1", 32'(a1), 32'd0);

    // Randomised run against the model.
    configure(7, 1, 3, 6);
    en = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      sys_rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ((!en && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
        presc_div = 8'($urandom_range(0, 3));
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = (wr_addr == 2'd2) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 14));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
